// File: rtl/ahb_frame_dma.sv
// ahb_frame_dma: AHB-Lite write master turning each 256-bit frame into one INCR8 burst into a memory ring.
// Latency: frame accepted at edge N -> NONSEQ after edge N+1; 8 address cycles + 1 trailing data cycle per burst.
// Backpressure: none upstream; a frame offered with no free buffer entry (or while in error) is dropped and flagged.
// Build option: define AHB_FRAME_DMA_DBLBUF_EN for a two-entry frame FIFO; default is a single entry.
module ahb_frame_dma (
    input  logic         hclk,
    input  logic         hresetn,
    input  logic         enable,
    input  logic [31:0]  baseAddr,
    input  logic [15:0]  ringFrames,
    input  logic         valid,
    input  logic [255:0] pdata,
    output logic         dropped,
    output logic         frameDone,
    output logic [15:0]  wrPtr,
    output logic         error,
    output logic [31:0]  haddr,
    output logic [1:0]   htrans,
    output logic         hwrite,
    output logic [2:0]   hsize,
    output logic [2:0]   hburst,
    output logic         hmastlock,
    output logic [31:0]  hwdata,
    input  logic         hready,
    input  logic [1:0]   hresp
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_SEQ, ST_LAST, ST_ERR} state_t;

    state_t       state_q;
    logic [2:0]   beat_q;
    logic [31:0]  haddr_q;
    logic [1:0]   htrans_q;
    logic         hwrite_q;
    logic [2:0]   hsize_q;
    logic [2:0]   hburst_q;
    logic [31:0]  hwdata_q;
    logic         dropped_q;
    logic         frame_done_q;
    logic [15:0]  wr_ptr_q;
    logic         error_q;

    logic         buf_vld_w;
    logic         buf_full_w;
    logic [255:0] head_dat_w;
    logic         done_w;
    logic         abort_w;
    logic         pop_w;
    logic         accept_w;
    logic [15:0]  ring_last_w;
    logic [31:0]  frame_addr_w;
    logic [31:0]  word_w;
    logic         unused_w;

    // Last data beat of the burst accepted OKAY frees the head entry.
    assign done_w   = (state_q == ST_LAST) && hready && !hresp[0];
    // Any ERROR response seen while our burst owns the bus abandons it.
    assign abort_w  = ((state_q == ST_SEQ) || (state_q == ST_LAST)) && hresp[0];
    assign pop_w    = done_w || abort_w;
    // A frame may take the slot that the completing burst releases this very cycle.
    assign accept_w = valid && enable && !error_q && (!buf_full_w || done_w);

    assign ring_last_w  = (ringFrames == 16'd0) ? 16'd0 : ringFrames - 16'd1;
    assign frame_addr_w = {baseAddr[31:5], 5'b0} + {11'd0, wr_ptr_q, 5'd0};
    // beat_q is 0 in ADDR, so the same select yields word 0 there and word k in SEQ.
    assign word_w       = head_dat_w[{beat_q, 5'b0} +: 32];
    assign unused_w     = ^{baseAddr[4:0], hresp[1]};

`ifdef AHB_FRAME_DMA_DBLBUF_EN
    logic [255:0] buf0_q;
    logic [255:0] buf1_q;
    logic         wr_sel_q;
    logic         rd_sel_q;
    logic [1:0]   cnt_q;

    assign buf_vld_w  = (cnt_q != 2'd0);
    assign buf_full_w = (cnt_q == 2'd2);
    assign head_dat_w = rd_sel_q ? buf1_q : buf0_q;

    // Two-entry ping-pong FIFO: push on accept, pop on burst completion or abort, arrival order kept.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            buf0_q   <= '0;
            buf1_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (accept_w) begin
                if (wr_sel_q) buf1_q <= pdata;
                else          buf0_q <= pdata;
                wr_sel_q <= ~wr_sel_q;
            end
            if (pop_w) rd_sel_q <= ~rd_sel_q;
            case ({accept_w, pop_w})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
`else
    logic [255:0] buf_q;
    logic         full_q;

    assign buf_vld_w  = full_q;
    assign buf_full_w = full_q;
    assign head_dat_w = buf_q;

    // Single frame entry: filled on accept, released on burst completion or abort.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            buf_q  <= '0;
            full_q <= 1'b0;
        end else if (accept_w) begin
            buf_q  <= pdata;
            full_q <= 1'b1;
        end else if (pop_w) begin
            full_q <= 1'b0;
        end
    end
`endif

    // Burst sequencer with registered AHB outputs and status pulses.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q      <= ST_IDLE;
            beat_q       <= 3'd0;
            haddr_q      <= 32'd0;
            htrans_q     <= HT_IDLE;
            hwrite_q     <= 1'b0;
            hsize_q      <= 3'd0;
            hburst_q     <= 3'd0;
            hwdata_q     <= 32'd0;
            dropped_q    <= 1'b0;
            frame_done_q <= 1'b0;
            wr_ptr_q     <= 16'd0;
            error_q      <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            dropped_q    <= valid && enable && !accept_w;
            if (abort_w) begin
                htrans_q <= HT_IDLE;
                hwrite_q <= 1'b0;
                error_q  <= 1'b1;
                state_q  <= ST_ERR;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        htrans_q <= HT_IDLE;
                        hwrite_q <= 1'b0;
                        if (buf_vld_w) begin
                            state_q  <= ST_ADDR;
                            haddr_q  <= frame_addr_w;
                            htrans_q <= HT_NONSEQ;
                            hwrite_q <= 1'b1;
                            hsize_q  <= 3'b010;
                            hburst_q <= 3'b011;
                            beat_q   <= 3'd0;
                        end
                    end
                    ST_ADDR: begin
                        if (hready) begin
                            hwdata_q <= word_w;
                            haddr_q  <= haddr_q + 32'd4;
                            htrans_q <= HT_SEQ;
                            beat_q   <= 3'd1;
                            state_q  <= ST_SEQ;
                        end
                    end
                    ST_SEQ: begin
                        if (hready) begin
                            hwdata_q <= word_w;
                            if (beat_q == 3'd7) begin
                                htrans_q <= HT_IDLE;
                                state_q  <= ST_LAST;
                            end else begin
                                haddr_q <= haddr_q + 32'd4;
                                beat_q  <= beat_q + 3'd1;
                            end
                        end
                    end
                    ST_LAST: begin
                        if (hready) begin
                            frame_done_q <= 1'b1;
                            wr_ptr_q     <= (wr_ptr_q >= ring_last_w) ? 16'd0 : wr_ptr_q + 16'd1;
                            hwrite_q     <= 1'b0;
                            state_q      <= ST_IDLE;
                        end
                    end
                    ST_ERR: begin
                        htrans_q <= HT_IDLE;
                        hwrite_q <= 1'b0;
                        if (!enable) begin
                            error_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign haddr     = haddr_q;
    assign htrans    = htrans_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hburst    = hburst_q;
    assign hmastlock = 1'b0;
    assign hwdata    = hwdata_q;
    assign dropped   = dropped_q;
    assign frameDone = frame_done_q;
    assign wrPtr     = wr_ptr_q;
    assign error     = error_q;

endmodule

// File: tb/tb_ahb_frame_dma.sv
// tb_ahb_frame_dma: directed scenarios plus randomized traffic against a transaction-level ring model.
// Latency: checks are evaluated 1 time unit after each rising edge using the values held before that edge.
// Backpressure: the bench acts as AHB slave and inserts random or directed wait states and ERROR responses.
module tb_ahb_frame_dma;

`ifdef AHB_FRAME_DMA_DBLBUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic         hclk;
    logic         hresetn;
    logic         enable;
    logic [31:0]  baseAddr;
    logic [15:0]  ringFrames;
    logic         valid;
    logic [255:0] pdata;
    logic         dropped;
    logic         frameDone;
    logic [15:0]  wrPtr;
    logic         error;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic         hwrite;
    logic [2:0]   hsize;
    logic [2:0]   hburst;
    logic         hmastlock;
    logic [31:0]  hwdata;
    logic         hready;
    logic [1:0]   hresp;

    int checks = 0;
    int errors = 0;

    logic [255:0] fq[$];
    logic [31:0]  starts[$];
    int           m_ptr, a_beat, dp_beat, idle_cnt, done_cnt, wait_pct;
    bit           m_err, dp_vld, hold_slave;

    ahb_frame_dma dut (
        .hclk(hclk), .hresetn(hresetn), .enable(enable), .baseAddr(baseAddr),
        .ringFrames(ringFrames), .valid(valid), .pdata(pdata), .dropped(dropped),
        .frameDone(frameDone), .wrPtr(wrPtr), .error(error), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hmastlock(hmastlock), .hwdata(hwdata), .hready(hready), .hresp(hresp)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_frame();
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    task automatic model_reset();
        fq.delete();
        m_ptr = 0; m_err = 0; a_beat = 0; dp_vld = 0; dp_beat = 0; idle_cnt = 0;
    endtask

    // One clock: remember the cycle's inputs/outputs, advance, then score what the edge should have done.
    task automatic step();
        logic [1:0]   p_htrans, p_hresp;
        logic [31:0]  p_haddr, p_hwdata, p_base;
        logic         p_hready, p_valid, p_en, p_hw;
        logic [2:0]   p_hsize, p_hburst;
        logic [15:0]  p_rf;
        logic [255:0] p_pdata, h;
        bit           abort, free, exp_done, exp_drop, err_pre;
        int           sz, rf;
        if (!hold_slave) begin
            hready = ($urandom_range(99) < 32'(wait_pct)) ? 1'b0 : 1'b1;
            hresp  = 2'b00;
        end
        p_htrans = htrans; p_hresp = hresp; p_haddr = haddr; p_hwdata = hwdata;
        p_base = baseAddr; p_hready = hready; p_valid = valid; p_en = enable;
        p_hw = hwrite; p_hsize = hsize; p_hburst = hburst; p_rf = ringFrames; p_pdata = pdata;
        @(posedge hclk);
        #1;
        abort = 0; free = 0; exp_done = 0; exp_drop = 0;
        err_pre = m_err;
        sz = fq.size();
        rf = (p_rf == 16'd0) ? 1 : int'(p_rf);
        // data phase outcome
        if (dp_vld && p_hresp[0] && !p_hready) begin
            abort = 1;
            h = fq.pop_front();
            m_err = 1; dp_vld = 0; a_beat = 0;
            chk("err_htrans", 32'(htrans), 0);
        end else if (dp_vld && p_hready) begin
            h = fq[0];
            chk("hwdata", p_hwdata, h[dp_beat*32 +: 32]);
            dp_vld = 0;
            if (dp_beat == 7) begin
                free = 1; exp_done = 1; done_cnt++;
                h = fq.pop_front();
                m_ptr = (m_ptr >= rf - 1) ? 0 : m_ptr + 1;
                a_beat = 0;
            end
        end else if (dp_vld) begin
            chk("hwdata_hold", hwdata, p_hwdata);
        end
        // address phase outcome
        if (!abort && p_htrans[1]) begin
            if (p_hready) begin
                chk("htrans", 32'(p_htrans), (a_beat == 0) ? 32'd2 : 32'd3);
                chk("haddr", p_haddr, {p_base[31:5], 5'b0} + 32'(m_ptr) * 32 + 32'(a_beat) * 4);
                chk("attr", 32'({p_hw, p_hsize, p_hburst}), 32'h53);
                chk("burst_src", 32'(sz > 0), 1);
                if (a_beat == 0) starts.push_back(p_haddr);
                if (sz > 0) dp_vld = 1;
                dp_beat = a_beat;
                a_beat++;
            end else begin
                chk("haddr_hold", haddr, p_haddr);
                chk("htrans_hold", 32'(htrans), 32'(p_htrans));
            end
        end
        // frame acceptance
        if (p_valid && p_en) begin
            if (!err_pre && (sz < DEPTH || free)) fq.push_back(p_pdata);
            else exp_drop = 1;
        end
        if (err_pre && !p_en) m_err = 0;
        chk("dropped", 32'(dropped), 32'(exp_drop));
        chk("frameDone", 32'(frameDone), 32'(exp_done));
        chk("wrPtr", 32'(wrPtr), 32'(m_ptr));
        chk("error", 32'(error), 32'(m_err));
        chk("hmastlock", 32'(hmastlock), 0);
        if (m_err) chk("err_quiet", 32'(htrans), 0);
        if (a_beat == 8) chk("last_idle", 32'(htrans), 0);
        if (!m_err && fq.size() > 0 && a_beat == 0 && htrans != 2'b10) begin
            idle_cnt++;
            chk("start_lat", 32'(idle_cnt <= 1), 1);
        end else begin
            idle_cnt = 0;
        end
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(input logic [255:0] f);
        valid = 1'b1;
        pdata = f;
        step();
        valid = 1'b0;
    endtask

    // Called #1 after an edge; reset is asserted and released away from the clock edge.
    task automatic do_reset();
        valid = 1'b0;
        #2 hresetn = 1'b0;
        #1 model_reset();
        @(posedge hclk);
        #1 hresetn = 1'b1;
    endtask

    initial begin
        logic [255:0] w;
        int           n;
        hresetn = 1'b0; enable = 1'b0; valid = 1'b0; pdata = '0;
        baseAddr = 32'h1000; ringFrames = 16'd2; hready = 1'b1; hresp = 2'b00;
        wait_pct = 0; hold_slave = 0; done_cnt = 0;
        model_reset();
        #12;
        chk("rst_haddr", haddr, 0);
        chk("rst_htrans", 32'(htrans), 0);
        chk("rst_hwdata", hwdata, 0);
        chk("rst_attr", 32'({hwrite, hsize, hburst, hmastlock}), 0);
        chk("rst_status", 32'({dropped, frameDone, error}), 0);
        chk("rst_wrptr", 32'(wrPtr), 0);
        @(posedge hclk);
        #1 hresetn = 1'b1;
        enable = 1'b1;

        // three frames into a two-frame ring, zero waits
        starts.delete(); done_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            send(rand_frame());
            idle(11);
        end
        chk("t1_nstarts", 32'(starts.size()), 3);
        if (starts.size() == 3) begin
            chk("t1_start0", starts[0], 32'h1000);
            chk("t1_start1", starts[1], 32'h1020);
            chk("t1_start2", starts[2], 32'h1000);
        end
        chk("t1_done", 32'(done_cnt), 3);
        chk("t1_ptr", 32'(wrPtr), 1);

        // three wait states on beat 4
        do_reset();
        w = rand_frame();
        send(w);
        n = 0;
        while (!(htrans == 2'b11 && haddr == 32'h1010) && n < 40) begin step(); n++; end
        chk("t2_found", 32'(n < 40), 1);
        hold_slave = 1; hready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_haddr", haddr, 32'h1010);
            chk("t2_hwdata", hwdata, w[127:96]);
        end
        hold_slave = 0;
        done_cnt = 0;
        idle(10);
        chk("t2_done", 32'(done_cnt), 1);

        // ERROR on the beat 2 data phase
        do_reset();
        send(rand_frame());
        idle(11);
        send(rand_frame());
        n = 0;
        while (!(dp_vld && dp_beat == 2) && n < 40) begin step(); n++; end
        chk("t3_found", 32'(n < 40), 1);
        hold_slave = 1; hready = 1'b0; hresp = 2'b01;
        step();
        chk("t3_htrans", 32'(htrans), 0);
        chk("t3_error", 32'(error), 1);
        chk("t3_ptr", 32'(wrPtr), 1);
        hready = 1'b1;
        step();
        hresp = 2'b00; hold_slave = 0;
        idle(2);
        send(rand_frame());
        chk("t3_drop", 32'(dropped), 1);
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        chk("t3_clear", 32'(error), 0);
        starts.delete();
        send(rand_frame());
        idle(11);
        chk("t3_reuse", (starts.size() > 0) ? starts[0] : 32'hFFFF_FFFF, 32'h1020);

        // second frame three cycles after the first
        do_reset();
        done_cnt = 0;
        send(rand_frame());
        idle(2);
        send(rand_frame());
`ifdef AHB_FRAME_DMA_DBLBUF_EN
        chk("t4_drop", 32'(dropped), 0);
        idle(25);
        chk("t4_done", 32'(done_cnt), 2);
`else
        chk("t4_drop", 32'(dropped), 1);
        idle(25);
        chk("t4_done", 32'(done_cnt), 1);
`endif

        // reset in the middle of a burst
        do_reset();
        send(rand_frame());
        idle(11);
        send(rand_frame());
        n = 0;
        while (a_beat != 3 && n < 40) begin step(); n++; end
        chk("t5_found", 32'(n < 40), 1);
        #2 hresetn = 1'b0;
        #1;
        chk("t5_htrans", 32'(htrans), 0);
        chk("t5_ptr", 32'(wrPtr), 0);
        chk("t5_error", 32'(error), 0);
        chk("t5_haddr", haddr, 0);
        model_reset();
        @(posedge hclk);
        #1 hresetn = 1'b1;
        starts.delete();
        send(rand_frame());
        idle(11);
        chk("t5_base", (starts.size() > 0) ? starts[0] : 32'hFFFF_FFFF, 32'h1000);

        // zero-depth ring behaves as depth one
        do_reset();
        ringFrames = 16'd0;
        starts.delete();
        for (int k = 0; k < 3; k++) begin
            send(rand_frame());
            idle(11);
        end
        chk("t6_nstarts", 32'(starts.size()), 3);
        foreach (starts[k]) chk("t6_start", starts[k], 32'h1000);

        // randomized traffic with wait states, enable toggles and ring resizes
        do_reset();
        baseAddr = 32'h2000_005C;
        ringFrames = 16'd3;
        wait_pct = 25;
        for (int c = 0; c < 3000; c++) begin
            valid = ($urandom_range(99) < 12);
            if (valid) pdata = rand_frame();
            if ($urandom_range(199) == 0) enable = ~enable;
            if ($urandom_range(499) == 0) ringFrames = 16'($urandom_range(5));
            step();
        end
        valid = 1'b0;
        enable = 1'b1;
        wait_pct = 0;
        idle(30);
        chk("rnd_idle", 32'(htrans), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_frame_dma.md
# ahb_frame_dma

- AHB-Lite write master that moves 256-bit parallel frames (8 × 32-bit channels, as produced by the TDM-to-parallel path) into a memory ring buffer.
- Each accepted frame becomes one INCR8 burst of eight 32-bit words.
- It is the initiator counterpart to the AHB slave register interface and sits in the hclk domain beside it.
- Frame input and ring configuration arrive already synchronous to hclk.

## Interface
- No parameters; frame size fixed at 8 words / 32 bytes.
- hclk  in  1  bus clock; all logic on rising edge.
- hresetn  in  1  reset; asynchronous assert, active-low.
- enable  in  1  1 = accept frames and issue bursts.
- baseAddr  in  32  ring base; bits [4:0] ignored, treated as 0.
- ringFrames  in  16  ring depth in frames; 0 treated as 1.
- valid  in  1  single-cycle frame strobe.
- pdata  in  256  frame; word k = pdata[32k+31:32k].
- dropped  out  1  one-cycle pulse: frame offered but not accepted.
- frameDone  out  1  one-cycle pulse: burst completed OKAY.
- wrPtr  out  16  next ring frame index.
- error  out  1  sticky; bus ERROR seen.
- haddr  out  32; htrans  out  2; hwrite  out  1; hsize  out  3; hburst  out  3; hmastlock  out  1; hwdata  out  32.
- hready  in  1; hresp  in  2 (bit 0 = ERROR).

## Operation
- Buffer: one frame entry (see Configuration). A valid is accepted when enable=1, error=0, and a buffer entry is free, or is being freed that same cycle.
  - Otherwise the frame is discarded and dropped pulses the next cycle.
  - valid with enable=0 is ignored and does not pulse dropped.
- FSM states:
  - IDLE: htrans=IDLE, hwrite=0. If the buffer holds a frame → ADDR.
  - ADDR: NONSEQ, beat 0.
  - SEQ: beats 1–7.
  - LAST: final data phase, htrans=IDLE.
  - ERR: bus quiet.
- Transitions:
  - ADDR → SEQ on hready.
  - SEQ → LAST after beat 7 address is accepted.
  - LAST → IDLE on hready with OKAY.
- Burst attributes: hwrite=1, hsize=3'b010, hburst=3'b011 (INCR8), hmastlock=0.
- Addressing: haddr = {baseAddr[31:5],5'b0} + wrPtr*32 + beat*4.
  - Aligned 32-byte bursts never cross 1 KB; no burst splitting.
- Pipeline: hwdata carries word k during the data phase of beat k, one cycle after its address phase.
  - While hready=0, all outputs (haddr, htrans, hwdata) hold.
- Completion: the last data beat accepted OKAY frees the buffer entry and pulses frameDone. wrPtr increments, wrapping to 0 when wrPtr = max(ringFrames,1)−1.
- ERROR response (hresp=ERROR, hready=0, first cycle):
  - Next cycle drive htrans=IDLE and abandon the burst.
  - Discard the frame; do not advance wrPtr; set error; enter ERR.
- ERR: no bursts, no accepts (each valid pulses dropped). Exit to IDLE when enable=0, which also clears error.
- enable falling mid-burst: the burst completes normally; any remaining buffered frame is still written; new frames are refused.
- ringFrames change: takes effect at the next wrap check. If wrPtr ≥ new depth, wrPtr wraps to 0 at the next completion.

## Timing
- Reset values: haddr 0, htrans 2'b00, hwrite 0, hsize 0, hburst 0, hmastlock 0, hwdata 0, dropped 0, frameDone 0, wrPtr 0, error 0, FSM IDLE, buffer empty.
- valid accepted at edge N → NONSEQ driven after edge N+1.
- Zero wait states: 8 address cycles + 1 trailing data cycle. frameDone is high the cycle after the last data beat.
- At least one IDLE htrans cycle (LAST) separates bursts.
- Back-to-back frame rate: one per 10 cycles.
- Reset mid-burst: outputs return to reset values asynchronously; the buffered frame is lost.

## Configuration
- AHB_FRAME_DMA_DBLBUF_EN defined: two-entry FIFO buffer. One frame can be captured while the other bursts, and frames are written in arrival order. A third frame arriving while both entries are occupied is dropped.
- Undefined: single entry. A valid during a burst is dropped unless it coincides with the freeing LAST cycle.

## Test plan
- ringFrames=2, baseAddr=0x1000, zero waits, frames A,B,C:
  - Bursts go to 0x1000, 0x1020, then 0x1000 again.
  - hwdata follows A[31:0]..A[255:224].
  - wrPtr sequence 1,0,1; three frameDone pulses.
- hready low for 3 cycles on beat 4: haddr 0x1010 (SEQ) and hwdata of word 3 hold for 3 cycles; the burst then completes intact.
- ERROR response on beat 2 data phase: htrans=IDLE next cycle, error=1, wrPtr unchanged.
  - A subsequent valid pulses dropped.
  - enable 0→1 clears error and the next burst reuses the same address.
- Second valid 3 cycles after the first:
  - Without AHB_FRAME_DMA_DBLBUF_EN: dropped pulses.
  - With it: two bursts are written in order.
- Assert hresetn mid-SEQ: htrans=0, wrPtr=0, error=0 immediately. After release, a new frame bursts to baseAddr.
- ringFrames=0: every burst targets baseAddr and wrPtr stays 0.
